attention_fetch_scheduler: RTL and testbench
============================================

ATTENTION_FETCH_SCHEDULER -- requirements
Module: attention_fetch_scheduler

Interface
REQ-001 Parameter NUM_PASSES, default 2, number of K-then-Q fetch pairs per job (range 1..255).
REQ-002 Parameter SETUP_CYCLES, default 2, cycles each buffer select is held before start_fetch (range 1..15).
REQ-003 Parameter TIMEOUT_CYCLES, default 65535, watchdog limit in WAIT; used only with SCHED_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 job_start  input  1  single-cycle request to run one attention fetch job; sampled only in IDLE.
REQ-007 fetch_done  input  1  completion from the fetch unit; valid only in WAIT.
REQ-008 fetch_busy  input  1  fetch unit busy; start_fetch is never issued while high.
REQ-009 start_fetch  output  1  single-cycle fetch launch pulse.
REQ-010 reset_addr_counter  output  1  fetch address-counter clear, held for SETUP_CYCLES.
REQ-011 Buffer_Select  output  3  buffer code: K=3'b100, Q=3'b011, V=3'b101.
REQ-012 Tiles_Control  output  1  1 = 32-tile (stationary/weight) mode, 0 = 512-tile mode.
REQ-013 busy  output  1  high from job acceptance until return to IDLE.
REQ-014 job_done  output  1  single-cycle pulse when the V fetch completes.
REQ-015 pass_idx  output  8  index of the current K/Q pass.
REQ-016 timeout_err  output  1  sticky watchdog error flag.

Function
REQ-017 States: IDLE, SETUP, LAUNCH, WAIT, ADVANCE, DONE, ERR.
REQ-018 Fetch order per job: for p=0..NUM_PASSES-1 {K, Q}, then one V; total 2*NUM_PASSES+1 fetches.
REQ-019 K fetch drives Buffer_Select=3'b100, Tiles_Control=1; Q and V drive Tiles_Control=0.
REQ-020 IDLE->SETUP on job_start=1; pass_idx cleared, first step K, busy asserts next cycle.
REQ-021 SETUP holds Buffer_Select/Tiles_Control stable for exactly SETUP_CYCLES cycles, then ->LAUNCH.
REQ-022 reset_addr_counter is high during all SETUP cycles of only the first K fetch and the first Q fetch of a job; low otherwise (K and Q resume their address counters on later passes).
REQ-023 LAUNCH asserts start_fetch for exactly one cycle when fetch_busy=0, then ->WAIT; stalls in LAUNCH with start_fetch=0 while fetch_busy=1.
REQ-024 WAIT ignores fetch_done in the cycle start_fetch is high; first fetch_done=1 thereafter ->ADVANCE.
REQ-025 ADVANCE: K->Q same pass; Q->K with pass_idx+1 if pass_idx<NUM_PASSES-1, else ->V; V->DONE; non-DONE targets go to SETUP.
REQ-026 DONE pulses job_done for one cycle, then ->IDLE; busy drops in the IDLE cycle.
REQ-027 job_start outside IDLE is ignored (no queuing).
REQ-028 Buffer_Select and Tiles_Control hold their last values in IDLE and DONE; no glitches within a fetch step.
REQ-029 fetch_done in IDLE, SETUP or LAUNCH is ignored.
REQ-030 All outputs registered; no combinational input-to-output path.

Reset
REQ-031 rst_n=0 at any rising edge, including mid-job, forces IDLE next cycle: start_fetch=0, reset_addr_counter=0, Buffer_Select=3'b000, Tiles_Control=0, busy=0, job_done=0, pass_idx=0, timeout_err=0, watchdog=0.

Configuration
REQ-032 Macro SCHED_TIMEOUT_EN defined: a 16-bit watchdog counts WAIT cycles; reaching TIMEOUT_CYCLES ->ERR, timeout_err=1 sticky, busy=0, no further fetches; ERR exits only on reset.
REQ-033 SCHED_TIMEOUT_EN undefined: no watchdog logic, ERR unreachable, timeout_err tied 0, WAIT indefinitely.

Verification
REQ-034 NUM_PASSES=2, fetch_done 20 cycles after each start_fetch -> Buffer_Select sequence 100,011,100,011,101; Tiles_Control 1,0,1,0,0; 5 start_fetch pulses; one job_done.
REQ-035 Same run -> reset_addr_counter high exactly 2 cycles before fetch 1 and 2 cycles before fetch 2, never before fetches 3-5.
REQ-036 fetch_busy held high 7 cycles at LAUNCH -> start_fetch delayed 7 cycles, still one cycle wide.
REQ-037 rst_n low 1 cycle during 3rd fetch WAIT -> all outputs at reset values next cycle; fresh job_start restarts at K with reset_addr_counter asserted.
REQ-038 SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100, no fetch_done -> timeout_err=1 after 100 WAIT cycles, busy=0, job_done never pulses.
REQ-039 job_start repeated while busy=1 -> ignored; exactly one job_done.

Source files
------------

// File: rtl/attention_fetch_scheduler.sv
// attention_fetch_scheduler: sequences NUM_PASSES K/Q fetch pairs then one V fetch per job.
// Optional WAIT watchdog enabled by defining SCHED_TIMEOUT_EN.
module attention_fetch_scheduler #(
  parameter int NUM_PASSES     = 2,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       job_start,
  input  logic       fetch_done,
  input  logic       fetch_busy,
  output logic       start_fetch,
  output logic       reset_addr_counter,
  output logic [2:0] Buffer_Select,
  output logic       Tiles_Control,
  output logic       busy,
  output logic       job_done,
  output logic [7:0] pass_idx,
  output logic       timeout_err
);
  typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, WAIT, ADVANCE, DONE, ERR} state_t;
  typedef enum logic [1:0] {STEP_K, STEP_Q, STEP_V} step_t;
  localparam logic [2:0] SEL_K = 3'b100;
  localparam logic [2:0] SEL_Q = 3'b011;
  localparam logic [2:0] SEL_V = 3'b101;
  state_t     state;
  step_t      step;
  logic [3:0] setup_cnt;
`ifdef SCHED_TIMEOUT_EN
  logic [15:0] watchdog;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      step               <= STEP_K;
      setup_cnt          <= '0;
      start_fetch        <= 1'b0;
      reset_addr_counter <= 1'b0;
      Buffer_Select      <= 3'b000;
      Tiles_Control      <= 1'b0;
      busy               <= 1'b0;
      job_done           <= 1'b0;
      pass_idx           <= '0;
      timeout_err        <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      watchdog           <= '0;
`endif
    end else begin
      start_fetch <= 1'b0;
      job_done    <= 1'b0;
      case (state)
        IDLE: if (job_start) begin
          state              <= SETUP;
          step               <= STEP_K;
          pass_idx           <= '0;
          setup_cnt          <= '0;
          Buffer_Select      <= SEL_K;
          Tiles_Control      <= 1'b1;
          reset_addr_counter <= 1'b1;
          busy               <= 1'b1;
        end
        SETUP: if (setup_cnt == 4'(SETUP_CYCLES - 1)) begin
          state              <= LAUNCH;
          reset_addr_counter <= 1'b0;
        end else setup_cnt <= setup_cnt + 4'd1;
        LAUNCH: if (!fetch_busy) begin
          start_fetch <= 1'b1;
          state       <= WAIT;
`ifdef SCHED_TIMEOUT_EN
          watchdog    <= '0;
`endif
        end
        WAIT: begin
          // a done coincident with the launch pulse belongs to an earlier fetch
          if (!start_fetch && fetch_done) state <= ADVANCE;
`ifdef SCHED_TIMEOUT_EN
          else if (watchdog == 16'(TIMEOUT_CYCLES - 1)) begin
            state       <= ERR;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
          end else watchdog <= watchdog + 16'd1;
`endif
        end
        ADVANCE: begin
          setup_cnt          <= '0;
          state              <= SETUP;
          reset_addr_counter <= (step == STEP_K) && (pass_idx == '0);
          if (step == STEP_K) begin
            step          <= STEP_Q;
            Buffer_Select <= SEL_Q;
            Tiles_Control <= 1'b0;
          end else if (step == STEP_Q && pass_idx < 8'(NUM_PASSES - 1)) begin
            step          <= STEP_K;
            pass_idx      <= pass_idx + 8'd1;
            Buffer_Select <= SEL_K;
            Tiles_Control <= 1'b1;
          end else if (step == STEP_Q) begin
            step          <= STEP_V;
            Buffer_Select <= SEL_V;
            Tiles_Control <= 1'b0;
          end else begin
            state    <= DONE;
            job_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_attention_fetch_scheduler.sv
// tb_attention_fetch_scheduler: directed checks of fetch order, setup/clear timing, stalls and reset.
module tb_attention_fetch_scheduler;
  logic       clk = 0;
  logic       rst_n, job_start, fetch_done, fetch_busy;
  logic       start_fetch, reset_addr_counter, Tiles_Control, busy, job_done, timeout_err;
  logic [2:0] Buffer_Select;
  logic [7:0] pass_idx;
  int errors = 0, checks = 0;
  int nf, ndone, dbl, rac_run, g;
  logic prev_sf = 0;
  logic [2:0] sel_log [16];
  logic       tc_log  [16];
  int         rac_log [16];
  logic [2:0] exp_sel [5] = '{3'b100, 3'b011, 3'b100, 3'b011, 3'b101};
  logic       exp_tc  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  int         exp_rac [5] = '{2, 2, 0, 0, 0};

  attention_fetch_scheduler #(.NUM_PASSES(2), .SETUP_CYCLES(2), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start), .fetch_done(fetch_done),
    .fetch_busy(fetch_busy), .start_fetch(start_fetch), .reset_addr_counter(reset_addr_counter),
    .Buffer_Select(Buffer_Select), .Tiles_Control(Tiles_Control), .busy(busy),
    .job_done(job_done), .pass_idx(pass_idx), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_fetch) begin
      if (nf < 16) begin
        sel_log[nf] = Buffer_Select;
        tc_log[nf]  = Tiles_Control;
        rac_log[nf] = rac_run;
      end
      nf++;
      rac_run = 0;
      if (prev_sf) dbl++;
    end else if (reset_addr_counter) rac_run++;
    if (job_done) ndone++;
    prev_sf = start_fetch;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    @(posedge clk);
    nf = 0; ndone = 0; dbl = 0; rac_run = 0;
    @(negedge clk);
  endtask

  task automatic pulse_job();
    job_start = 1;
    @(negedge clk);
    job_start = 0;
  endtask

  task automatic wait_sf(output int gap);
    gap = 0;
    while (!start_fetch && gap < 200) begin
      @(negedge clk);
      gap++;
    end
  endtask

  task automatic serve(input bit stall, output int gap);
    gap = 0;
    fetch_done = 1;
    @(negedge clk);
    gap++;
    fetch_done = 0;
    fetch_busy = stall;
    while (!start_fetch && gap < 200) begin
      @(negedge clk);
      gap++;
      if (gap == 11) fetch_busy = 0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sf"}, start_fetch, 0);
    check({tag, "_rac"}, reset_addr_counter, 0);
    check({tag, "_sel"}, Buffer_Select, 0);
    check({tag, "_tc"}, Tiles_Control, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, job_done, 0);
    check({tag, "_pass"}, pass_idx, 0);
    check({tag, "_terr"}, timeout_err, 0);
  endtask

  task automatic job(input int stall_idx, input bit dup_start);
    int gp;
    pulse_job();
    check("busy_start", busy, 1);
    wait_sf(gp);
    check("gap_first", gp, 3);
    for (int i = 0; i < 4; i++) begin
      repeat (18) @(negedge clk);
      job_start = dup_start;
      @(negedge clk);
      job_start = 0;
      serve(i == stall_idx, gp);
      check("gap_next", gp, (i == stall_idx) ? 12 : 5);
    end
    repeat (19) @(negedge clk);
    fetch_done = 1;
    @(negedge clk);
    fetch_done = 0;
    @(negedge clk);
    check("job_done_hi", job_done, 1);
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("job_done_lo", job_done, 0);
    check("busy_idle", busy, 0);
    repeat (30) @(negedge clk);
    check("no_extra_fetch", nf, 5);
    check("one_job_done", ndone, 1);
    check("sf_width", dbl, 0);
  endtask

  initial begin
    rst_n = 0; job_start = 0; fetch_done = 0; fetch_busy = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    rst_n = 1;
    fetch_done = 1;
    @(negedge clk);
    fetch_done = 0;
    @(negedge clk);
    check("idle_done_busy", busy, 0);
    check("idle_done_sf", start_fetch, 0);
    // main sequence with repeated job_start while busy
    clear_log();
    job(-1, 1);
    for (int i = 0; i < 5; i++) begin
      check("seq_sel", sel_log[i], exp_sel[i]);
      check("seq_tc", tc_log[i], exp_tc[i]);
      check("seq_rac", rac_log[i], exp_rac[i]);
    end
    check("hold_sel_idle", Buffer_Select, 3'b101);
    // fetch_done during the launch cycle must not advance
    clear_log();
    pulse_job();
    wait_sf(g);
    fetch_done = 1;
    @(negedge clk);
    fetch_done = 0;
    repeat (8) @(negedge clk);
    check("ign_done_sel", Buffer_Select, 3'b100);
    check("ign_done_nf", nf, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check_reset_vals("rst1");
    // fetch_busy stall before the third launch
    clear_log();
    job(1, 0);
    // reset during third fetch WAIT, then restart
    clear_log();
    pulse_job();
    wait_sf(g);
    for (int i = 0; i < 2; i++) begin
      repeat (19) @(negedge clk);
      serve(0, g);
    end
    check("p1_pass", pass_idx, 1);
    check("p1_sel", Buffer_Select, 3'b100);
    repeat (5) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check_reset_vals("rst2");
    clear_log();
    pulse_job();
    wait_sf(g);
    check("restart_gap", g, 3);
    check("restart_sel", Buffer_Select, 3'b100);
    check("restart_tc", Tiles_Control, 1);
    check("restart_rac", rac_log[0], 2);
`ifdef SCHED_TIMEOUT_EN
    repeat (99) @(negedge clk);
    check("wd_pre", timeout_err, 0);
    @(negedge clk);
    check("wd_err", timeout_err, 1);
    check("wd_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("wd_sticky", timeout_err, 1);
    check("wd_no_done", ndone, 0);
    check("wd_no_fetch", nf, 1);
`endif
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check_reset_vals("rst3");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
